// File: rtl/seg_scan6.sv
// Six-digit multiplexed 7-segment scan driver with dead time, frame-latched shadows and blink.
// All pin outputs are registered and reflect the (cnt, idx) state of the previous cycle.
module seg_scan6 #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEAD         = 2,
    parameter int BLINK_FRAMES = 64,
    parameter int SEG_ACT_LOW  = 1,
    parameter int DIG_ACT_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] h10,
    input  logic [6:0] h1,
    input  logic [6:0] m10,
    input  logic [6:0] m1,
    input  logic [6:0] s10,
    input  logic [6:0] s1,
    input  logic       blink_en,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic [5:0] an_out,
    output logic       frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] LAST_CNT   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_CNT   = CW'(DEAD);
    localparam logic [FW-1:0] LAST_FRAME = FW'(BLINK_FRAMES - 1);
    localparam logic SEG_INV = (SEG_ACT_LOW != 0);
    localparam logic DIG_INV = (DIG_ACT_LOW != 0);

    typedef enum logic {VISIBLE = 1'b0, HIDDEN = 1'b1} phase_t;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [FW-1:0] frame_cnt;
    phase_t        phase;
    logic [6:0]    sh_h10, sh_h1, sh_m10, sh_m1, sh_s10, sh_s1;

    logic       wrap_slot;
    logic       wrap_frame;
    logic       visible;
    logic       active;
    logic [6:0] shadow_sel;
    logic [5:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;

    assign wrap_slot  = (cnt == LAST_CNT);
    assign wrap_frame = wrap_slot && (idx == 3'd5);
    // blink_en low overrides the stored phase so visibility returns on the very next output
    assign visible    = !blink_en || (phase == VISIBLE);
    assign active     = visible && (cnt >= DEAD_CNT);

    always_comb begin
        shadow_sel = 7'h00;
        case (idx)
            3'd0:    shadow_sel = sh_h10;
            3'd1:    shadow_sel = sh_h1;
            3'd2:    shadow_sel = sh_m10;
            3'd3:    shadow_sel = sh_m1;
            3'd4:    shadow_sel = sh_s10;
            3'd5:    shadow_sel = sh_s1;
            default: shadow_sel = 7'h00;
        endcase
    end

    assign an_n  = active ? (6'b100000 >> idx) : 6'b000000;
    assign seg_n = active ? shadow_sel : 7'h00;
    assign dp_n  = active && ((idx == 3'd1) || (idx == 3'd3));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 3'd0;
            frame_cnt  <= '0;
            phase      <= VISIBLE;
            sh_h10     <= 7'h00;
            sh_h1      <= 7'h00;
            sh_m10     <= 7'h00;
            sh_m1      <= 7'h00;
            sh_s10     <= 7'h00;
            sh_s1      <= 7'h00;
            frame_tick <= 1'b0;
            an_out     <= {6{DIG_INV}};
            seg_out    <= {7{SEG_INV}};
            dp_out     <= SEG_INV;
        end else begin
            cnt <= wrap_slot ? '0 : cnt + CW'(1);
            if (wrap_slot) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end

            // Latch all six digits at once so a displayed frame never mixes old and new time
            if (wrap_frame) begin
                sh_h10 <= h10;
                sh_h1  <= h1;
                sh_m10 <= m10;
                sh_m1  <= m1;
                sh_s10 <= s10;
                sh_s1  <= s1;
            end
            frame_tick <= wrap_frame;

            if (!blink_en) begin
                frame_cnt <= '0;
                phase     <= VISIBLE;
            end else if (wrap_frame) begin
                if (frame_cnt == LAST_FRAME) begin
                    frame_cnt <= '0;
                    phase     <= (phase == VISIBLE) ? HIDDEN : VISIBLE;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end

            an_out  <= an_n ^ {6{DIG_INV}};
            seg_out <= seg_n ^ {7{SEG_INV}};
            dp_out  <= dp_n ^ SEG_INV;
        end
    end

endmodule

// File: tb/tb_seg_scan6.sv
// Directed bench for seg_scan6 with SCAN_DIV=4, DEAD=1, BLINK_FRAMES=2, active-low pins.
// Expected pin values are derived per cycle from the slot/offset position within a 24-cycle frame.
module tb_seg_scan6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] h10, h1, m10, m1, s10, s1;
    logic       blink_en = 1'b0;
    logic [6:0] seg_out;
    logic       dp_out;
    logic [5:0] an_out;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    logic started = 1'b0;

    // Slot 0 (h10) in the low bits: digits 1,2,3,4,5,0 then 6,7,8,9,5,4
    localparam logic [41:0] PAT_P = {7'h3F, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    localparam logic [41:0] PAT_Q = {7'h66, 7'h6D, 7'h6F, 7'h7F, 7'h07, 7'h7D};

    seg_scan6 #(
        .SCAN_DIV(4), .DEAD(1), .BLINK_FRAMES(2), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst(rst),
        .h10(h10), .h1(h1), .m10(m10), .m1(m1), .s10(s10), .s1(s1),
        .blink_en(blink_en),
        .seg_out(seg_out), .dp_out(dp_out), .an_out(an_out), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic [41:0] p);
        h10 = p[6:0];
        h1  = p[13:7];
        m10 = p[20:14];
        m1  = p[27:21];
        s10 = p[34:28];
        s1  = p[41:35];
    endtask

    task automatic check_inactive(input string tag);
        check({tag, "_an"}, 32'(an_out), 32'h3F);
        check({tag, "_seg"}, 32'(seg_out), 32'h7F);
        check({tag, "_dp"}, 32'(dp_out), 32'h1);
        check({tag, "_tick"}, 32'(frame_tick), 32'h0);
    endtask

    // j = 1..24 counts cycles after a frame_tick cycle; j = 24 is the next frame_tick
    task automatic expect_slot(input int j, input logic [41:0] pats, input logic vis);
        int         slot;
        int         c;
        logic       act;
        logic [5:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_dp;
        slot    = (j - 1) / 4;
        c       = (j - 1) % 4;
        act     = vis && (c >= 1);
        exp_an  = act ? ~(6'b100000 >> slot) : 6'h3F;
        exp_seg = act ? ~pats[slot*7 +: 7] : 7'h7F;
        exp_dp  = (act && (slot == 1 || slot == 3)) ? 1'b0 : 1'b1;
        check($sformatf("an_j%0d", j), 32'(an_out), 32'(exp_an));
        check($sformatf("seg_j%0d", j), 32'(seg_out), 32'(exp_seg));
        check($sformatf("dp_j%0d", j), 32'(dp_out), 32'(exp_dp));
        check($sformatf("tick_j%0d", j), 32'(frame_tick), (j == 24) ? 32'h1 : 32'h0);
    endtask

    task automatic run_frame(input logic [41:0] pats, input int vis_from, input int stop_at,
                             input int chg_at, input logic [41:0] new_in, input int drop_at);
        for (int j = 1; j <= stop_at; j++) begin
            step();
            expect_slot(j, pats, j >= vis_from);
            if (j == chg_at) set_inputs(new_in);
            if (j == drop_at) blink_en = 1'b0;
        end
    endtask

    // Frame after reset shows blank segments; first frame_tick lands 24 cycles after release
    task automatic wait_blank_frame(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
            check({tag, "_blank_seg"}, 32'(seg_out), 32'h7F);
        end while (!frame_tick && n <= 40);
        check({tag, "_tick_latency"}, 32'(n), 32'd24);
    endtask

    // Continuous properties: at most one digit enabled, frame_tick spacing of 24 cycles
    int   since = 0;
    logic since_valid = 1'b0;
    always @(negedge clk) begin
        if (started) begin
            check("onehot", 32'($countones(~an_out) <= 1), 32'h1);
            if (rst) begin
                since_valid = 1'b0;
                since = 0;
            end else begin
                since = since + 1;
                if (frame_tick) begin
                    if (since_valid) check("tick_period", 32'(since), 32'd24);
                    since = 0;
                    since_valid = 1'b1;
                end
            end
        end
    end

    initial begin
        set_inputs(PAT_P);
        rst = 1'b1;
        step();
        started = 1'b1;
        step();
        check_inactive("reset");

        rst = 1'b0;
        wait_blank_frame("first");
        run_frame(PAT_P, 1, 24, 0, 42'h0, 0);
        run_frame(PAT_P, 1, 24, 10, PAT_Q, 0);
        run_frame(PAT_Q, 1, 24, 0, 42'h0, 0);

        blink_en = 1'b1;
        run_frame(PAT_Q, 1, 24, 0, 42'h0, 0);
        run_frame(PAT_Q, 1, 24, 0, 42'h0, 0);
        run_frame(PAT_Q, 25, 24, 0, 42'h0, 0);
        run_frame(PAT_Q, 25, 24, 0, 42'h0, 0);
        run_frame(PAT_Q, 1, 24, 0, 42'h0, 0);
        run_frame(PAT_Q, 1, 24, 0, 42'h0, 0);
        run_frame(PAT_Q, 10, 24, 0, 42'h0, 9);
        run_frame(PAT_Q, 1, 24, 0, 42'h0, 0);

        // Stop while the DUT sits at idx=3, cnt=2 and reset there
        run_frame(PAT_Q, 1, 14, 0, 42'h0, 0);
        rst = 1'b1;
        step();
        check_inactive("midrst");
        rst = 1'b0;
        wait_blank_frame("after_rst");
        run_frame(PAT_Q, 1, 24, 0, 42'h0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
